shared_mem_arbiter: RTL

Parametrised arbiter giving NUM_PORTS pipeline requesters (instruction fetch, data access, future DMA/debug) access to one single-port synchronous memory. Replaces the ad-hoc per-cycle IF/MEM address multiplexing in the CPU top with an explicit req/gnt handshake and a tagged read-return path. Sits between the pipeline stage logic and the shared memory; one command issued per cycle, read data returned one cycle later to the originating port only.

---
 rtl/shared_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/shared_mem_arbiter.sv
// Arbiter that shares one single-port synchronous memory among NUM_PORTS requesters, with a tagged one-cycle read return.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; by default the highest-index requester wins.
module shared_mem_arbiter #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int NUM_PORTS = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    output logic                        mem_re,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int PID_W = $clog2(NUM_PORTS);

    logic [PID_W-1:0]     sel_s;
    logic                 found_s;
    logic                 grant_s;
    logic [NUM_PORTS-1:0] rvalid_r;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [PID_W:0]   NP_W  = (PID_W+1)'(NUM_PORTS);
    localparam logic [PID_W-1:0] LAST_P = PID_W'(NUM_PORTS - 1);
    localparam logic [PID_W-1:0] ONE_P  = PID_W'(1);

    logic [PID_W-1:0] ptr_r;
    logic [PID_W-1:0] ptr_nxt_s;
    logic [PID_W:0]   cand_s;

    // Scan from farthest to nearest candidate so the one closest to the pointer is kept.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        cand_s  = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            cand_s = {1'b0, ptr_r} + (PID_W+1)'(k);
            if (cand_s >= NP_W) begin
                cand_s = cand_s - NP_W;
            end else begin
                cand_s = cand_s;
            end
            if (req[cand_s[PID_W-1:0]]) begin
                sel_s   = cand_s[PID_W-1:0];
                found_s = 1'b1;
            end else begin
                sel_s   = sel_s;
                found_s = found_s;
            end
        end
    end

    // Pointer step past the winner, wrapping at the last port.
    always_comb begin
        if (sel_s == LAST_P) begin
            ptr_nxt_s = '0;
        end else begin
            ptr_nxt_s = sel_s + ONE_P;
        end
    end

    // Round-robin pointer moves only on cycles that issue a command.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (grant_s) begin
            ptr_r <= ptr_nxt_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: ascending scan leaves the highest-index requester selected.
    always_comb begin
        sel_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i]) begin
                sel_s   = PID_W'(i);
                found_s = 1'b1;
            end else begin
                sel_s   = sel_s;
                found_s = found_s;
            end
        end
    end
`endif

    // Grants are suppressed while reset is held so no command leaks out.
    assign grant_s = found_s & reset_n;

    // Route the winner's command to the memory; all outputs idle to zero otherwise.
    always_comb begin
        gnt       = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_s && (sel_s == PID_W'(i))) begin
                gnt[i]    = 1'b1;
                mem_addr  = addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata[i*DATA_W +: DATA_W];
                mem_we    = we[i];
                mem_re    = ~we[i];
            end else begin
                gnt[i]    = 1'b0;
            end
        end
    end

    // Pending-read tag: one-hot of the port whose read was issued last cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rvalid_r <= '0;
        end else if (mem_re) begin
            rvalid_r <= gnt;
        end else begin
            rvalid_r <= '0;
        end
    end

    assign rvalid = rvalid_r;
    assign rdata  = (|rvalid_r) ? mem_rdata : '0;

endmodule
